// File: rtl/floatingpointpkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | floatingpointpkg                                                     |
// | Single-precision float type and dispatcher shared definitions.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package floatingpointpkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float;

    typedef struct packed {
        float a;
        float b;
    } operand_pair_t;

    localparam float QNAN = '{sign: 1'b0, exp: 8'hFF, frac: 23'h400000};

    typedef logic [2:0] dispatch_state_t;

    localparam dispatch_state_t ST_IDLE   = 3'd0;
    localparam dispatch_state_t ST_ISSUE  = 3'd1;
    localparam dispatch_state_t ST_BUSY   = 3'd2;
    localparam dispatch_state_t ST_SETTLE = 3'd3;
    localparam dispatch_state_t ST_DONE   = 3'd4;

    function automatic logic is_zero(input float f);
        return (f.exp == 8'h00) && (f.frac == 23'h0);
    endfunction

    function automatic logic is_inf(input float f);
        return (f.exp == 8'hFF) && (f.frac == 23'h0);
    endfunction

    function automatic logic is_nan(input float f);
        return (f.exp == 8'hFF) && (f.frac != 23'h0);
    endfunction

    // Sum when at least one operand is a signed zero; -0 + -0 keeps the sign.
    function automatic float bypass_sum(input float a, input float b);
        if (is_zero(a) && is_zero(b)) begin
            return '{sign: a.sign & b.sign, exp: 8'h00, frac: 23'h0};
        end
        if (is_zero(a)) begin
            return b;
        end
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_operand_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_operand_fifo                                                      |
// | Operand-pair FIFO; wrap bit on each pointer separates full/empty.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_operand_fifo
    import floatingpointpkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          push_i,
    input  operand_pair_t data_i,
    input  logic          pop_i,
    output operand_pair_t data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    operand_pair_t mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_add_dispatcher                                                    |
// | Queues operand pairs, issues them to the FP adder with a watchdog.   |
// | Optional zero-operand bypass: define FPADD_ZERO_BYPASS_EN.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_add_dispatcher
    import floatingpointpkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic Clock,
    input  logic Reset,
    input  logic InValid,
    output logic InReady,
    input  float InA,
    input  float InB,
    output float AddendA,
    output float AddendB,
    output logic Go,
    input  float Result,
    input  logic ResultReady,
    input  logic Zero,
    input  logic Inf,
    input  logic Nan,
    output logic OutValid,
    input  logic OutReady,
    output float OutResult,
    output logic OutZero,
    output logic OutInf,
    output logic OutNan,
    output logic OutError
);

    localparam int              WW      = $clog2(TIMEOUT);
    localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);

    dispatch_state_t state_q, state_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            rdy_prev_q;
    float            addend_a_q, addend_a_d;
    float            addend_b_q, addend_b_d;
    float            out_result_q, out_result_d;
    logic [3:0]      out_flags_q, out_flags_d;   // {zero, inf, nan, error}
    logic            go_q;
    logic            valid_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    operand_pair_t   fifo_head;
    logic            completion;

    fp_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (InValid),
        .data_i  ('{a: InA, b: InB}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign InReady    = !fifo_full;
    assign completion = ResultReady && !rdy_prev_q;

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        addend_a_d   = addend_a_q;
        addend_b_d   = addend_b_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    addend_a_d = fifo_head.a;
                    addend_b_d = fifo_head.b;
                    wdog_d     = '0;
`ifdef FPADD_ZERO_BYPASS_EN
                    if (is_zero(fifo_head.a) || is_zero(fifo_head.b)) begin
                        out_result_d = bypass_sum(fifo_head.a, fifo_head.b);
                        out_flags_d  = {is_zero(out_result_d), is_inf(out_result_d),
                                        is_nan(out_result_d), 1'b0};
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (completion) begin
                    state_d = ST_SETTLE;
                end else if (wdog_q == WD_LAST) begin
                    out_result_d = QNAN;
                    out_flags_d  = 4'b0011;
                    state_d      = ST_DONE;
                end else if (wdog_q != {WW{1'b1}}) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                // Adder result has had a full cycle to settle after its edge.
                out_result_d = Result;
                out_flags_d  = {Zero, Inf, Nan, 1'b0};
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            wdog_q       <= '0;
            rdy_prev_q   <= 1'b0;
            addend_a_q   <= '0;
            addend_b_q   <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            go_q         <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            rdy_prev_q   <= ResultReady;
            addend_a_q   <= addend_a_d;
            addend_b_q   <= addend_b_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            go_q         <= (state_d == ST_ISSUE);
            valid_q      <= (state_d == ST_DONE);
        end
    end

    assign AddendA   = addend_a_q;
    assign AddendB   = addend_b_q;
    assign Go        = go_q;
    assign OutValid  = valid_q;
    assign OutResult = out_result_q;
    assign OutZero   = out_flags_q[3];
    assign OutInf    = out_flags_q[2];
    assign OutNan    = out_flags_q[1];
    assign OutError  = out_flags_q[0];

endmodule
`default_nettype wire
